board_reset_sequencer: RTL and testbench
========================================

Name: board_reset_sequencer

Overview:
- Board-level upstream stage that produces the processor-tile reset and system-enable, e.g. for aeMB_IP.
- Debounces a raw active-low push button and stretches the resulting reset for a programmable hold time.
- Delays sys_ena after reset release.
- Replaces the chained pair of signal holders in board top levels with one sequenced FSM, and counts button-initiated resets.

Parameters:
- DEBOUNCE_COUNT, 50000: consecutive identical synchronized key samples required to change the debounced level (>=1).
- RESET_HOLD, 1000: cycles sys_reset stays high after the sequence starts (>=1).
- ENA_DELAY, 100: cycles between sys_reset falling and sys_ena rising (>=1).
- WDT_COUNT, 1000000: watchdog timeout in cycles (>=2; used only with WDT_EN).

Ports:
- clk, input, 1: system clock; all logic on its rising edge.
- reset, input, 1: board reset; synchronous, active-low.
- key_n, input, 1: raw push button; active-low, asynchronous, bouncing.
- sys_reset, output, 1: active-high reset to the downstream IP; registered.
- sys_ena, output, 1: active-high enable to the downstream IP; registered.
- key_pressed, output, 1: debounced button level; 1 = pressed.
- press_cnt, output, 8: number of debounced presses since reset; wraps 255->0.
- wdt_kick, input, 1: watchdog service pulse (WDT_EN only).
- wdt_fired, output, 1: sticky watchdog-expiry flag (WDT_EN only).

Behaviour:
- Synchronous active-low reset (reset=0 at a clk edge) forces:
  - 2-FF key synchronizer to 1, debounced level to 0, debounce counter to 0.
  - state S_HOLD with counter 0.
  - sys_reset=1, sys_ena=0, key_pressed=0, press_cnt=0, wdt_fired=0.
- Synchronizer: key_n passes through two flops; the sampled value is ks = ~sync2.
- Debounce:
  - When ks differs from the debounced level, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_COUNT-1 while ks still differs, the debounced level toggles and the counter clears.
  - Net latency: key_pressed rises DEBOUNCE_COUNT+2 cycles after a stable key_n fall; same for release.
- Counters: width $clog2(max(RESET_HOLD,ENA_DELAY,WDT_COUNT)+1).
- FSM state S_HOLD:
  - Outputs: sys_reset=1, sys_ena=0.
  - Counter increments each cycle.
  - At count RESET_HOLD-1, go to S_WAIT and clear the counter.
  - Net: after reset deasserts, sys_reset is high for exactly RESET_HOLD cycles.
- FSM state S_WAIT:
  - Outputs: sys_reset=0, sys_ena=0.
  - At count ENA_DELAY-1, go to S_RUN.
  - Net: sys_ena rises exactly ENA_DELAY cycles after sys_reset falls.
- FSM state S_RUN:
  - Outputs: sys_reset=0, sys_ena=1.
  - Stays until a key press or watchdog expiry.
- FSM state S_KEY:
  - Outputs: sys_reset=1, sys_ena=0.
  - Stays while key_pressed=1.
  - On the debounced release, go to S_HOLD with counter 0; the full hold/wait sequence follows.
- Key press:
  - The 0->1 edge of key_pressed, in any state (including mid-S_HOLD or mid-S_WAIT), forces S_KEY on the next edge.
  - Same edge: sys_reset=1 and sys_ena=0.
  - press_cnt increments once per 0->1 edge.
- Bounce shorter than DEBOUNCE_COUNT samples: no effect on any output.
- Priority, highest first: reset, key press edge, watchdog expiry, normal sequencing.
- No combinational paths from inputs to outputs.

Optional Feature:
- Macro: BOARD_RESET_SEQ_WDT_EN.
- Defined:
  - Adds ports wdt_kick and wdt_fired, plus a watchdog counter.
  - The watchdog counter runs only in S_RUN and clears on leaving S_RUN.
  - wdt_kick=1 clears the counter that cycle; a kick on the expiry cycle wins and prevents expiry.
  - When the count reaches WDT_COUNT-1 without a kick: go to S_HOLD with counter 0 and set wdt_fired=1.
  - wdt_fired is cleared only by reset or a key press edge.
- Undefined:
  - Ports wdt_kick and wdt_fired are absent and no watchdog logic is built.
  - S_RUN is left only by a key press.

Test Plan (DEBOUNCE_COUNT=4, RESET_HOLD=10, ENA_DELAY=5, WDT_COUNT=20):
- Hold reset=0 for 3 cycles, then release with key_n=1 -> sys_reset=1 for exactly 10 cycles, then sys_ena=0 for 5 cycles, then sys_ena=1; press_cnt=0.
- In S_RUN, pulse key_n low for 3 cycles, then high -> no change on sys_reset, sys_ena, key_pressed or press_cnt.
- In S_RUN, hold key_n low for 20 cycles, then high -> key_pressed rises 6 cycles after the fall; sys_reset=1 and sys_ena=0 on the next edge; sys_reset stays high until 10 cycles after the debounced release; press_cnt=1.
- Press the key stably while in S_WAIT (cycle 12) -> sequence aborts to S_KEY and restarts the full 10+5 cycles after release.
- Press 256 times -> press_cnt wraps to 0.
- BOARD_RESET_SEQ_WDT_EN defined:
  - Kick every 15 cycles -> stays in S_RUN.
  - Stop kicking -> after 20 cycles, sys_reset=1 for 10 cycles and wdt_fired=1 stays set.
  - A subsequent key press clears wdt_fired.
  - A kick on the 20th cycle -> no expiry.

Source files
------------

// File: rtl/board_reset_sequencer.sv
// Board reset sequencer: debounces the push button, stretches the downstream reset, then delays sys_ena.
// Define BOARD_RESET_SEQ_WDT_EN to add a watchdog (wdt_kick / wdt_fired) that restarts the sequence.
module board_reset_sequencer #(
  parameter int DEBOUNCE_COUNT = 50000,
  parameter int RESET_HOLD     = 1000,
  parameter int ENA_DELAY      = 100,
  parameter int WDT_COUNT      = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  output logic       sys_reset,
  output logic       sys_ena,
  output logic       key_pressed,
  output logic [7:0] press_cnt
`ifdef BOARD_RESET_SEQ_WDT_EN
  ,
  input  logic       wdt_kick,
  output logic       wdt_fired
`endif
);

  localparam int MAX_HW  = (RESET_HOLD > ENA_DELAY) ? RESET_HOLD : ENA_DELAY;
  localparam int MAX_ALL = (MAX_HW > WDT_COUNT) ? MAX_HW : WDT_COUNT;
  localparam int CW      = $clog2(MAX_ALL + 1);
  localparam int DW      = (DEBOUNCE_COUNT > 1) ? $clog2(DEBOUNCE_COUNT) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_COUNT - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(ENA_DELAY - 1);

  localparam logic [1:0] S_HOLD = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_KEY  = 2'd3;

  logic          sync1_q, sync2_q;
  logic          key_sample;
  logic          deb_q, deb_d, deb_prev_q;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          press_edge;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] seq_cnt_q, seq_cnt_d;
  logic          sys_reset_q, sys_reset_d;
  logic          sys_ena_q, sys_ena_d;
  logic [7:0]    press_cnt_q, press_cnt_d;
  logic          wdt_expire;

  assign key_sample = ~sync2_q;
  assign press_edge = deb_q & ~deb_prev_q;

  // Debounce: the level flips only after DEBOUNCE_COUNT consecutive differing samples.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (key_sample != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = ~deb_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  // Two-flop synchronizer in front of the debouncer; key_n is fully asynchronous.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      deb_cnt_q  <= '0;
    end else begin
      sync1_q    <= key_n;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

`ifdef BOARD_RESET_SEQ_WDT_EN
  localparam logic [CW-1:0] WDT_LAST = CW'(WDT_COUNT - 1);

  logic [CW-1:0] wdt_cnt_q, wdt_cnt_d;
  logic          wdt_fired_q, wdt_fired_d;

  // Counter only advances in S_RUN; a kick on the expiry cycle still wins.
  always_comb begin
    wdt_expire  = 1'b0;
    wdt_cnt_d   = '0;
    wdt_fired_d = wdt_fired_q;
    if (state_q == S_RUN) begin
      if (wdt_kick) begin
        wdt_cnt_d = '0;
      end else if (wdt_cnt_q == WDT_LAST) begin
        wdt_expire = 1'b1;
      end else begin
        wdt_cnt_d = wdt_cnt_q + 1'b1;
      end
    end
    if (press_edge) begin
      wdt_fired_d = 1'b0;
    end else if (wdt_expire) begin
      wdt_fired_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wdt_cnt_q   <= '0;
      wdt_fired_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_fired_q <= wdt_fired_d;
    end
  end

  assign wdt_fired = wdt_fired_q;
`else
  assign wdt_expire = 1'b0;
`endif

  // Sequencer: a press edge overrides everything, then watchdog, then normal hold/wait/run.
  always_comb begin
    state_d     = state_q;
    seq_cnt_d   = '0;
    press_cnt_d = press_cnt_q;
    if (press_edge) begin
      state_d     = S_KEY;
      press_cnt_d = press_cnt_q + 8'd1;
    end else if (wdt_expire) begin
      state_d = S_HOLD;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (seq_cnt_q == HOLD_LAST) begin
            state_d = S_WAIT;
          end else begin
            seq_cnt_d = seq_cnt_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (seq_cnt_q == WAIT_LAST) begin
            state_d = S_RUN;
          end else begin
            seq_cnt_d = seq_cnt_q + 1'b1;
          end
        end
        S_RUN: state_d = S_RUN;
        S_KEY: begin
          if (!deb_q) begin
            state_d = S_HOLD;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end
    sys_reset_d = (state_d == S_HOLD) || (state_d == S_KEY);
    sys_ena_d   = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_HOLD;
      seq_cnt_q   <= '0;
      sys_reset_q <= 1'b1;
      sys_ena_q   <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      seq_cnt_q   <= seq_cnt_d;
      sys_reset_q <= sys_reset_d;
      sys_ena_q   <= sys_ena_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  assign sys_reset   = sys_reset_q;
  assign sys_ena     = sys_ena_q;
  assign key_pressed = deb_q;
  assign press_cnt   = press_cnt_q;

endmodule

// File: tb/tb_board_reset_sequencer.sv
// Scoreboard bench for board_reset_sequencer: a timestamp-based reference model predicts every cycle.
`timescale 1ns/1ps
module tb_board_reset_sequencer;

  localparam int DC = 4;
  localparam int RH = 10;
  localparam int ED = 5;
  localparam int WC = 20;
`ifdef BOARD_RESET_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  typedef enum int {M_HOLD, M_WAIT, M_RUN, M_KEY} mode_e;

  typedef struct packed {
    logic       sys_reset;
    logic       sys_ena;
    logic       key_pressed;
    logic [7:0] press_cnt;
    logic       wdt_fired;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       key_n = 1'b1;
  logic       wdt_kick = 1'b0;
  logic       sys_reset, sys_ena, key_pressed, wdt_fired_w;
  logic [7:0] press_cnt;

  always #5 clk = ~clk;

  board_reset_sequencer #(
    .DEBOUNCE_COUNT(DC), .RESET_HOLD(RH), .ENA_DELAY(ED), .WDT_COUNT(WC)
  ) dut (
    .clk(clk), .reset(reset), .key_n(key_n),
    .sys_reset(sys_reset), .sys_ena(sys_ena),
    .key_pressed(key_pressed), .press_cnt(press_cnt)
`ifdef BOARD_RESET_SEQ_WDT_EN
    , .wdt_kick(wdt_kick), .wdt_fired(wdt_fired_w)
`endif
  );
`ifndef BOARD_RESET_SEQ_WDT_EN
  assign wdt_fired_w = 1'b0;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  obs_t exp_q[$];

  // Reference model state: absolute edge numbers instead of counters.
  int    cyc = 0;
  bit    kn_hist[$];
  bit    ks_hist[$];
  bit    m_deb, m_pend, m_fired;
  mode_e m_mode = M_HOLD;
  int    m_start, m_ref, m_presses;
  int    kick_period = 0;

  task automatic check(input string name, input obs_t got, input obs_t want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s @%0t: got rst=%b ena=%b key=%b cnt=%0d wdt=%b, expected rst=%b ena=%b key=%b cnt=%0d wdt=%b",
               name, $time, got.sys_reset, got.sys_ena, got.key_pressed, got.press_cnt, got.wdt_fired,
               want.sys_reset, want.sys_ena, want.key_pressed, want.press_cnt, want.wdt_fired);
    end
  endtask

  function automatic obs_t model_outputs();
    obs_t o;
    o.sys_reset   = (m_mode == M_HOLD) || (m_mode == M_KEY);
    o.sys_ena     = (m_mode == M_RUN);
    o.key_pressed = m_deb;
    o.press_cnt   = 8'(m_presses % 256);
    o.wdt_fired   = m_fired;
    return o;
  endfunction

  // One rising edge of the reference: sequencing sees pre-edge levels, then the debouncer advances.
  task automatic model_edge();
    bit ks, old_deb, all_diff;
    cyc++;
    if (!reset) begin
      kn_hist = '{1'b1, 1'b1};
      ks_hist.delete();
      m_deb = 0; m_pend = 0; m_fired = 0;
      m_mode = M_HOLD; m_start = cyc; m_ref = cyc; m_presses = 0;
      return;
    end
    old_deb = m_deb;
    if (m_pend) begin
      m_mode = M_KEY; m_start = cyc; m_presses++; m_fired = 0;
    end else if (WDT_ON && m_mode == M_RUN && !wdt_kick && (cyc - m_ref) >= WC) begin
      m_mode = M_HOLD; m_start = cyc; m_fired = 1;
    end else begin
      case (m_mode)
        M_HOLD: if (cyc - m_start == RH) begin m_mode = M_WAIT; m_start = cyc; end
        M_WAIT: if (cyc - m_start == ED) begin m_mode = M_RUN; m_start = cyc; m_ref = cyc; end
        M_RUN:  if (wdt_kick) m_ref = cyc;
        M_KEY:  if (!old_deb) begin m_mode = M_HOLD; m_start = cyc; end
        default: ;
      endcase
    end
    kn_hist.push_back(key_n);
    if (kn_hist.size() > 3) void'(kn_hist.pop_front());
    ks = !kn_hist[0];
    ks_hist.push_back(ks);
    if (ks_hist.size() > DC) void'(ks_hist.pop_front());
    all_diff = (ks_hist.size() == DC);
    foreach (ks_hist[i]) if (ks_hist[i] == m_deb) all_diff = 0;
    m_pend = 0;
    if (all_diff) begin
      m_deb  = !m_deb;
      m_pend = m_deb;
    end
  endtask

  task automatic step(input bit rst_v, input bit kn_v, input bit kick_v);
    @(negedge clk);
    reset    = rst_v;
    key_n    = kn_v;
    wdt_kick = kick_v;
    @(posedge clk);
    model_edge();
    exp_q.push_back(model_outputs());
  endtask

  task automatic step_k(input bit kn_v);
    step(1'b1, kn_v, (kick_period > 0) && (cyc % kick_period == 0));
  endtask

  task automatic do_reset(input int n);
    repeat (n) step(1'b0, 1'b1, 1'b0);
  endtask

  // Monitor: outputs are registered, so each negedge shows the result of the preceding edge.
  initial begin
    obs_t got;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        got = {sys_reset, sys_ena, key_pressed, press_cnt, wdt_fired_w};
        check("outputs", got, exp_q.pop_front());
      end
    end
  end

  initial begin
    kick_period = WDT_ON ? 15 : 0;

    // Power-up sequence, then a short bounce that must be ignored.
    do_reset(3);
    repeat (25) step_k(1'b1);
    repeat (3)  step_k(1'b0);
    repeat (15) step_k(1'b1);

    // Long stable press from S_RUN and its release.
    repeat (20) step_k(1'b0);
    repeat (40) step_k(1'b1);

    // Debounced press landing during S_WAIT.
    do_reset(3);
    repeat (6)  step_k(1'b1);
    repeat (12) step_k(1'b0);
    repeat (40) step_k(1'b1);

    // Randomized key activity, kicks and occasional resets.
    for (int n = 0; n < 400; ) begin
      bit kn;
      int len;
      kn  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 8);
      for (int j = 0; j < len; j++) begin
        step(($urandom_range(0, 199) != 0), kn, ($urandom_range(0, 9) == 0));
        n++;
      end
    end

    // 256 clean presses wrap press_cnt back to zero.
    do_reset(2);
    for (int p = 0; p < 256; p++) begin
      repeat (7) step_k(1'b0);
      repeat (7) step_k(1'b1);
    end
    repeat (30) step_k(1'b1);

    if (WDT_ON) begin
      do_reset(3);
      kick_period = 15;
      repeat (60) step_k(1'b1);
      kick_period = 0;
      repeat (50) step_k(1'b1);
      repeat (10) step_k(1'b0);
      repeat (10) step_k(1'b1);
      for (int i = 0; i < 100 && m_mode != M_RUN; i++) step(1'b1, 1'b1, 1'b0);
      repeat (19) step(1'b1, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b1);
      repeat (25) step(1'b1, 1'b1, 1'b0);
    end

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
